// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and word/sum types used by the
// add primitive and the surrounding ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;
    typedef logic [ALU_WIDTH:0]   alu_sum_t;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell; chained by signed_adder to form a ripple-carry core.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_s;

    // Sum and carry of a single bit position.
    always_comb begin
        half_s = a ^ b;
        s      = half_s ^ cin;
        cout   = (a & b) | (cin & half_s);
    end

endmodule : full_adder

// File: rtl/signed_adder.sv
// SIZE-bit ripple-carry adder with one registered output stage and a valid flag.
// Optional two's-complement overflow output: define SIGNED_ADDER_TC_OVF_EN.
module signed_adder
    import alu_pkg::*;
#(
    parameter int SIZE = ALU_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    output logic            overflow,
    output logic [SIZE:0]   result
`ifdef SIGNED_ADDER_TC_OVF_EN
    ,
    output logic            tc_overflow
`endif
);

    logic [SIZE:0]   carry_s;
    logic [SIZE-1:0] sum_bits_s;
    logic [SIZE:0]   sum_s;

    logic [SIZE:0]   result_d;
    logic [SIZE:0]   result_q;
    logic            overflow_d;
    logic            overflow_q;
    logic            out_valid_d;
    logic            out_valid_q;

    assign carry_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < SIZE; i++) begin : g_ripple
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry_s[i]),
                .s    (sum_bits_s[i]),
                .cout (carry_s[i+1])
            );
        end
    endgenerate

    assign sum_s = {carry_s[SIZE], sum_bits_s};

    // Capture a new sum only when qualified; otherwise hold the last result.
    always_comb begin
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            result_d    = sum_s;
            overflow_d  = carry_s[SIZE];
            out_valid_d = 1'b1;
        end else begin
            result_d    = result_q;
            overflow_d  = overflow_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

`ifdef SIGNED_ADDER_TC_OVF_EN
    logic tc_overflow_d;
    logic tc_overflow_q;

    // Signed overflow: like-signed operands yielding a sum of the opposite sign.
    always_comb begin
        tc_overflow_d = tc_overflow_q;
        if (in_valid) begin
            tc_overflow_d = (a[SIZE-1] == b[SIZE-1]) && (sum_bits_s[SIZE-1] != a[SIZE-1]);
        end else begin
            tc_overflow_d = tc_overflow_q;
        end
    end

    // Registered alongside result so it shares the same latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_overflow_q <= 1'b0;
        end else begin
            tc_overflow_q <= tc_overflow_d;
        end
    end

    assign tc_overflow = tc_overflow_q;
`endif

endmodule : signed_adder

// File: tb/tb_signed_adder.sv
// Directed self-checking bench for signed_adder at SIZE=8 and SIZE=2.
module tb_signed_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       out_valid8;
    logic       overflow8;
    logic [8:0] result8;
    logic       out_valid2;
    logic       overflow2;
    logic [2:0] result2;
`ifdef SIGNED_ADDER_TC_OVF_EN
    logic       tc_overflow8;
    logic       tc_overflow2;
`endif

    int n_tests;
    int n_fail;

    signed_adder #(.SIZE(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a8),
        .b           (b8),
        .out_valid   (out_valid8),
        .overflow    (overflow8),
        .result      (result8)
`ifdef SIGNED_ADDER_TC_OVF_EN
        ,
        .tc_overflow (tc_overflow8)
`endif
    );

    signed_adder #(.SIZE(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a2),
        .b           (b2),
        .out_valid   (out_valid2),
        .overflow    (overflow2),
        .result      (result2)
`ifdef SIGNED_ADDER_TC_OVF_EN
        ,
        .tc_overflow (tc_overflow2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs on the falling edge, return 1 time unit after the next rising edge.
    task automatic cyc(input logic iv, input logic [7:0] av8, input logic [7:0] bv8,
                       input logic [1:0] av2, input logic [1:0] bv2);
        @(negedge clk);
        in_valid = iv;
        a8 = av8;
        b8 = bv8;
        a2 = av2;
        b2 = bv2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [8:0] r, input logic ov, input logic vld);
        check({tag, "_res8"}, 32'(result8), 32'(r));
        check({tag, "_ovf8"}, 32'(overflow8), 32'(ov));
        check({tag, "_vld8"}, 32'(out_valid8), 32'(vld));
    endtask

    task automatic chk2(input string tag, input logic [2:0] r, input logic ov, input logic vld);
        check({tag, "_res2"}, 32'(result2), 32'(r));
        check({tag, "_ovf2"}, 32'(overflow2), 32'(ov));
        check({tag, "_vld2"}, 32'(out_valid2), 32'(vld));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        a2 = 2'($urandom);
        b2 = 2'($urandom);

        // Reset held with qualified random operands across several edges.
        repeat (3) begin
            @(posedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            a2 = 2'($urandom);
            b2 = 2'($urandom);
        end
        #1;
        chk8("rst", 9'h000, 1'b0, 1'b0);
        chk2("rst", 3'b000, 1'b0, 1'b0);
`ifdef SIGNED_ADDER_TC_OVF_EN
        check("rst_tc8", 32'(tc_overflow8), 32'd0);
`endif

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk2("idle", 3'b000, 1'b0, 1'b0);

        // SIZE=2 sweep without carry, then with carry.
        @(negedge clk);
        check("lat_before_first", 32'(out_valid2), 32'd0);
        cyc(1'b1, 8'h00, 8'h00, 2'b00, 2'b00); chk2("00+00", 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b01, 2'b00); chk2("01+00", 3'b001, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b00, 2'b01); chk2("00+01", 3'b001, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b10, 2'b00); chk2("10+00", 3'b010, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b10, 2'b01); chk2("10+01", 3'b011, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b11, 2'b00); chk2("11+00", 3'b011, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b10, 2'b10); chk2("10+10", 3'b100, 1'b1, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b11, 2'b01); chk2("11+01", 3'b100, 1'b1, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b11, 2'b10); chk2("11+10", 3'b101, 1'b1, 1'b1);
        cyc(1'b1, 8'h00, 8'h00, 2'b11, 2'b11); chk2("11+11", 3'b110, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 8'h00, 2'b00, 2'b00); chk2("hold2", 3'b110, 1'b1, 1'b0);

        // SIZE=8 back-to-back stream, then idle with changing operands.
        cyc(1'b1, 8'hFF, 8'h01, 2'b00, 2'b00); chk8("ff+01", 9'h100, 1'b1, 1'b1);
        cyc(1'b1, 8'h7F, 8'h01, 2'b00, 2'b00); chk8("7f+01", 9'h080, 1'b0, 1'b1);
        cyc(1'b1, 8'h80, 8'h80, 2'b00, 2'b00); chk8("80+80", 9'h100, 1'b1, 1'b1);
        cyc(1'b0, 8'h12, 8'h34, 2'b01, 2'b01); chk8("hold8", 9'h100, 1'b1, 1'b0);
        cyc(1'b0, 8'h56, 8'h78, 2'b01, 2'b01); chk8("hold8b", 9'h100, 1'b1, 1'b0);

        cyc(1'b1, 8'h00, 8'h00, 2'b00, 2'b00); chk8("zero8", 9'h000, 1'b0, 1'b1);
        cyc(1'b1, 8'hFF, 8'hFF, 2'b00, 2'b00); chk8("ones8", 9'h1FE, 1'b1, 1'b1);
        cyc(1'b1, 8'h3C, 8'h5A, 2'b00, 2'b00); chk8("3c+5a", 9'h096, 1'b0, 1'b1);

        // Reset asserted between edges while a new operand pair is in flight.
        @(negedge clk);
        in_valid = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_rst", 9'h000, 1'b0, 1'b0);
        chk2("async_rst", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk8("rst_discard", 9'h000, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
        check("post_rst_lat", 32'(out_valid8), 32'd0);
        @(posedge clk);
        #1;
        chk8("post_rst", 9'h003, 1'b0, 1'b1);

`ifdef SIGNED_ADDER_TC_OVF_EN
        cyc(1'b1, 8'h7F, 8'h01, 2'b00, 2'b00);
        check("tc_7f01", 32'(tc_overflow8), 32'd1);
        check("ov_7f01", 32'(overflow8), 32'd0);
        cyc(1'b1, 8'h80, 8'hFF, 2'b00, 2'b00);
        check("tc_80ff", 32'(tc_overflow8), 32'd1);
        check("ov_80ff", 32'(overflow8), 32'd1);
        cyc(1'b1, 8'hFF, 8'h01, 2'b00, 2'b00);
        check("tc_ff01", 32'(tc_overflow8), 32'd0);
        check("ov_ff01", 32'(overflow8), 32'd1);
`endif

        cyc(1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
        check("final_idle", 32'(out_valid8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_signed_adder
